// File: rtl/gb_mem_pkg.sv
// Shared types and constants for the Game Boy cartridge flash read path.
package gb_mem_pkg;

   localparam int unsigned BANK_W              = 9;
   localparam int unsigned WORD_W              = 22;
   localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LATCH,
      S_HOLD
   } state_t;

   typedef logic [WORD_W-1:0] word_addr_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer chain with parameterized depth and asynchronous reset.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gb_flash_if.sv
// Game Boy ROM read bridge to a 16-bit flash, with a one-word cache so the
// odd byte of a just-fetched word is served without a second flash access.
module gb_flash_if
   import gb_mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gb_rd,
   input  logic [13:0]       gb_a,
   input  logic [BANK_W-1:0] rom_bank_a,
   output logic [WORD_W-1:0] flash_a,
   input  logic [15:0]       flash_d,
   output logic              flash_ce_b,
   output logic              flash_oe_b,
   output logic              flash_adv_b,
   output logic              flash_we_b,
   output logic [7:0]        gb_din,
   output logic              busy
);

   state_t     state, state_next;
   logic       rd_s, rd_d, rise, hit;
   logic [3:0] cnt;
   word_addr_t new_addr, addr_q, cache_tag;
   logic       sel_q, cache_valid;
   logic [15:0] buffer;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd (
      .clk   (clk),
      .reset (reset),
      .d     (gb_rd),
      .q     (rd_s)
   );

   assign rise     = rd_s & ~rd_d;
   assign new_addr = {rom_bank_a, gb_a[13:1]};
   assign hit      = cache_valid && (cache_tag == new_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (rise) state_next = hit ? S_HOLD : S_ADDR;
         S_ADDR:  state_next = S_WAIT;
         S_WAIT:  if (cnt == 4'(WAIT_CYCLES - 1)) state_next = S_LATCH;
         S_LATCH: state_next = S_HOLD;
         S_HOLD:  if (!rd_s) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      flash_ce_b  = 1'b1;
      flash_oe_b  = 1'b1;
      flash_adv_b = 1'b1;
      busy        = 1'b0;
      case (state)
         S_ADDR: begin
            flash_ce_b  = 1'b0;
            flash_adv_b = 1'b0;
            busy        = 1'b1;
         end
         S_WAIT: begin
            flash_ce_b = 1'b0;
            flash_oe_b = 1'b0;
            busy       = 1'b1;
         end
         S_LATCH: begin
            flash_ce_b = 1'b0;
            busy       = 1'b1;
         end
         default: ;
      endcase
   end

   // Edges arriving outside IDLE are dropped because rd_d tracks rd_s every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_d        <= 1'b0;
         cnt         <= '0;
         addr_q      <= '0;
         sel_q       <= 1'b0;
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         buffer      <= '1;
      end else begin
         rd_d <= rd_s;
         if (state == S_WAIT) cnt <= cnt + 4'd1;
         else                 cnt <= '0;
         if (state == S_IDLE && rise) begin
            addr_q <= new_addr;
            sel_q  <= gb_a[0];
         end
         if (state == S_LATCH) begin
            buffer      <= flash_d;
            cache_valid <= 1'b1;
            cache_tag   <= addr_q;
         end
      end
   end

   assign flash_a    = addr_q;
   assign flash_we_b = 1'b1;
   assign gb_din     = sel_q ? buffer[15:8] : buffer[7:0];

endmodule

// File: tb/tb_gb_flash_if.sv
// Bench for gb_flash_if: three instances (WAIT_CYCLES 1, 2, 7) share stimulus,
// a model cache predicts hit/miss and expected bytes via a scoreboard queue.
module tb_gb_flash_if;
   import gb_mem_pkg::*;

   localparam int unsigned NI   = 3;
   localparam int unsigned SYNC = 2;
   localparam int          WIN  = 26;
   localparam int          DROP = 14;

   function automatic int unsigned wc(input int unsigned i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 7;
   endfunction

   logic        clk = 1'b0;
   logic        reset, gb_rd;
   logic [13:0] gb_a;
   logic [8:0]  rom_bank_a;
   logic [15:0] flash_d;
   logic [21:0] flash_a [NI];
   logic        ce_b [NI], oe_b [NI], adv_b [NI], we_b [NI], busy [NI];
   logic [7:0]  gb_din [NI];

   int checks = 0;
   int errors = 0;

   always #30 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      gb_flash_if #(.WAIT_CYCLES(wc(g)), .SYNC_STAGES(SYNC)) dut (
         .clk         (clk),
         .reset       (reset),
         .gb_rd       (gb_rd),
         .gb_a        (gb_a),
         .rom_bank_a  (rom_bank_a),
         .flash_a     (flash_a[g]),
         .flash_d     (flash_d),
         .flash_ce_b  (ce_b[g]),
         .flash_oe_b  (oe_b[g]),
         .flash_adv_b (adv_b[g]),
         .flash_we_b  (we_b[g]),
         .gb_din      (gb_din[g]),
         .busy        (busy[g])
      );
   end

   typedef struct {
      logic [7:0]  din;
      bit          hit;
      logic [21:0] fa;
   } exp_t;

   exp_t        sb [$];
   bit          m_valid = 1'b0;
   logic [21:0] m_tag   = '0;
   logic [15:0] m_data  = '1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_read(input logic [8:0] bank, input logic [13:0] a,
                          input logic [15:0] data, input int drop_at, input bit retrig);
      exp_t        e;
      logic [21:0] wa;
      logic [15:0] w;
      int          adv [NI], oe [NI], bsy [NI], lat [NI];
      wa    = {bank, a[13:1]};
      e.hit = m_valid && (m_tag == wa);
      w     = e.hit ? m_data : data;
      e.din = a[0] ? w[15:8] : w[7:0];
      e.fa  = wa;
      if (!e.hit) begin
         m_valid = 1'b1;
         m_tag   = wa;
         m_data  = data;
      end
      sb.push_back(e);
      for (int unsigned i = 0; i < NI; i++) begin
         adv[i] = 0; oe[i] = 0; bsy[i] = 0; lat[i] = -1;
      end
      rom_bank_a = bank;
      gb_a       = a;
      flash_d    = data;
      gb_rd      = 1'b1;
      for (int k = 1; k <= WIN; k++) begin
         @(posedge clk); #1;
         for (int unsigned i = 0; i < NI; i++) begin
            if (!adv_b[i]) adv[i]++;
            if (!oe_b[i])  oe[i]++;
            if (busy[i])   bsy[i]++;
            if (lat[i] < 0 && !busy[i] && gb_din[i] == e.din) lat[i] = k - int'(SYNC);
         end
         if (k == drop_at) gb_rd = 1'b0;
         if (retrig && k == drop_at + 1) gb_rd = 1'b1;
         if (retrig && k == drop_at + 2) gb_rd = 1'b0;
      end
      e = sb.pop_front();
      for (int unsigned i = 0; i < NI; i++) begin
         check($sformatf("din_w%0d", wc(i)),  32'(gb_din[i]), 32'(e.din));
         check($sformatf("lat_w%0d", wc(i)),  32'(lat[i]), e.hit ? 32'd1 : 32'(3 + wc(i)));
         check($sformatf("adv_w%0d", wc(i)),  32'(adv[i]), e.hit ? 32'd0 : 32'd1);
         check($sformatf("oe_w%0d", wc(i)),   32'(oe[i]),  e.hit ? 32'd0 : 32'(wc(i)));
         check($sformatf("busy_w%0d", wc(i)), 32'(bsy[i]), e.hit ? 32'd0 : 32'(wc(i) + 2));
         check($sformatf("fa_w%0d", wc(i)),   32'(flash_a[i]), 32'(e.fa));
         check($sformatf("idle_w%0d", wc(i)),
               32'({ce_b[i], oe_b[i], adv_b[i], we_b[i], busy[i]}), 32'b11110);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int unsigned i = 0; i < NI; i++) begin
         check($sformatf("%s_strb_w%0d", tag, wc(i)),
               32'({ce_b[i], oe_b[i], adv_b[i], we_b[i], busy[i]}), 32'b11110);
         check($sformatf("%s_din_w%0d", tag, wc(i)), 32'(gb_din[i]), 32'hFF);
         check($sformatf("%s_fa_w%0d", tag, wc(i)),  32'(flash_a[i]), 32'h0);
      end
   endtask

   task automatic reset_mid_access();
      bit seen;
      seen       = 1'b0;
      rom_bank_a = 9'h001;
      gb_a       = 14'h0000;
      flash_d    = 16'hBEEF;
      gb_rd      = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk); #1;
         if (!oe_b[1]) seen = 1'b1;
      end
      check("rst_reach_wait", 32'(seen), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      gb_rd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      m_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      gb_rd      = 1'b0;
      gb_a       = '0;
      rom_bank_a = '0;
      flash_d    = 16'h0000;
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      do_read(9'h001, 14'h0000, 16'hA55A, DROP, 1'b0);  // miss, low byte 5A
      do_read(9'h001, 14'h0001, 16'h1234, DROP, 1'b0);  // hit, high byte A5 from cache
      do_read(9'h002, 14'h0000, 16'h3C96, DROP, 1'b0);  // miss, flash_a 004000
      reset_mid_access();
      do_read(9'h002, 14'h0001, 16'h7E81, DROP, 1'b0);  // was cached before reset: must miss
      do_read(9'h003, 14'h0000, 16'hC3D2, 2, 1'b1);     // short pulse plus ignored retrigger
      do_read(9'h003, 14'h0001, 16'h0000, DROP, 1'b0);  // hit on the short-pulse word
      do_read(9'h001, 14'h0000, 16'hA55A, DROP, 1'b0);  // miss again after tag moved

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
